// File: rtl/core_ctrl_fsm_if.sv
// Purpose: groups the fetch handshake, decoder results and sequencer outputs of core_ctrl_fsm.
// Ports  : master = sequencer side (drives fetch request, IR, PC, strobes, status);
//          slave  = memory/decoder/execute side (drives ack, fetched word, decode results, stall).
interface core_ctrl_fsm_if;
  // instruction fetch handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // instruction register and decoder results
  logic [31:0] ir;
  logic        ig_ex;
  logic        write_rd;
  logic        br_en;
  logic        link;
  logic [23:0] br_offset24;
  logic        br_reg;
  logic [31:0] rm_data;
  // execute handshake
  logic        ex_stall;
  // sequencer status and strobes
  logic [31:0] pc;
  logic        rf_we;
  logic        lr_we;
  logic [31:0] lr_data;
  logic [2:0]  state;
  logic        fetch_err;
  logic [31:0] instr_cnt;

  modport master (
    output imem_req, imem_addr, ir, pc, rf_we, lr_we, lr_data, state, fetch_err, instr_cnt,
    input  imem_ack, imem_rdata, ig_ex, write_rd, br_en, link, br_offset24, br_reg,
           rm_data, ex_stall
  );

  modport slave (
    input  imem_req, imem_addr, ir, pc, rf_we, lr_we, lr_data, state, fetch_err, instr_cnt,
    output imem_ack, imem_rdata, ig_ex, write_rd, br_en, link, br_offset24, br_reg,
           rm_data, ex_stall
  );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Purpose: multi-cycle fetch/decode/execute/writeback sequencer; owns PC, IR, branch target,
//          register-file write strobes, retired-instruction count and fetch-timeout halt.
// Ports  : clk, rst (async active-low); bus = core_ctrl_fsm_if.master (fetch handshake,
//          decoder results, execute stall, PC/IR/strobes/status outputs).
// Timing : 4 cycles per executed instruction, 2 per skipped one with zero-wait memory;
//          FETCH waits on imem_ack, EXECUTE waits on ex_stall; all outputs registered.
module core_ctrl_fsm #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  core_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  // Counter value seen during the last permitted FETCH cycle (counter starts at 0).
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] cnt_q;
  logic [31:0] lr_data_q;
  logic [31:0] tgt_q;
  logic [7:0]  tmo_q;
  logic        imem_req_q;
  logic        rf_we_q;
  logic        lr_we_q;
  logic        fetch_err_q;
  // decoder results captured in DECODE
  logic        write_rd_q;
  logic        br_en_q;
  logic        link_q;
  logic        br_reg_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] rel_tgt_d;
  logic [31:0] next_pc_d;

  always_comb begin
    pc_plus4_d = pc_q + 32'd4;
    // Relative branch is based on pc+8 with a word-scaled, sign-extended offset.
    rel_tgt_d  = pc_q + 32'd8 + {{6{bus.br_offset24[23]}}, bus.br_offset24, 2'b00};
    next_pc_d  = br_en_q ? tgt_q : pc_plus4_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      cnt_q       <= '0;
      lr_data_q   <= RESET_PC + 32'd4;
      tgt_q       <= '0;
      tmo_q       <= '0;
      imem_req_q  <= 1'b0;
      rf_we_q     <= 1'b0;
      lr_we_q     <= 1'b0;
      fetch_err_q <= 1'b0;
      write_rd_q  <= 1'b0;
      br_en_q     <= 1'b0;
      link_q      <= 1'b0;
      br_reg_q    <= 1'b0;
    end else begin
      // Write strobes are single-cycle: only the EXECUTE->WRITEBACK edge raises them.
      rf_we_q <= 1'b0;
      lr_we_q <= 1'b0;
      case (state_q)
        S_RESET: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
          tmo_q      <= '0;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir_q       <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (tmo_q == TMO_LAST) begin
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= S_HALT;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (bus.ig_ex) begin
            // Skipped instruction retires straight from DECODE.
            pc_q       <= pc_plus4_d;
            lr_data_q  <= pc_plus4_d + 32'd4;
            cnt_q      <= cnt_q + 32'd1;
            imem_req_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_FETCH;
          end else begin
            write_rd_q <= bus.write_rd;
            br_en_q    <= bus.br_en;
            link_q     <= bus.link;
            br_reg_q   <= bus.br_reg;
            tgt_q      <= rel_tgt_d;
            state_q    <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (!bus.ex_stall) begin
            // Register-target branch uses the operand from the final EXECUTE cycle.
            if (br_reg_q) begin
              tgt_q <= bus.rm_data & 32'hFFFF_FFFE;
            end
            rf_we_q <= write_rd_q;
            lr_we_q <= br_en_q & link_q;
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          pc_q       <= next_pc_d;
          lr_data_q  <= next_pc_d + 32'd4;
          cnt_q      <= cnt_q + 32'd1;
          imem_req_q <= 1'b1;
          tmo_q      <= '0;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= S_RESET;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.pc        = pc_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.lr_we     = lr_we_q;
  assign bus.lr_data   = lr_data_q;
  assign bus.state     = state_q;
  assign bus.fetch_err = fetch_err_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Purpose: directed self-checking bench for core_ctrl_fsm.
// Ports  : none; drives the slave side of core_ctrl_fsm_if and clk/rst.
// Timing : inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_core_ctrl_fsm;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DEC   = 3'd2;
  localparam logic [2:0] ST_EXE   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [31:0] cur_pc;
  logic [31:0] exp_cnt;

  core_ctrl_fsm_if bus_if ();

  core_ctrl_fsm #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string pfx);
    check({pfx, "_state"},   32'(bus_if.state), 32'(ST_RESET));
    check({pfx, "_pc"},      bus_if.pc,        32'h0);
    check({pfx, "_addr"},    bus_if.imem_addr, 32'h0);
    check({pfx, "_ir"},      bus_if.ir,        32'h0);
    check({pfx, "_cnt"},     bus_if.instr_cnt, 32'h0);
    check({pfx, "_req"},     32'(bus_if.imem_req),  32'h0);
    check({pfx, "_rf_we"},   32'(bus_if.rf_we),     32'h0);
    check({pfx, "_lr_we"},   32'(bus_if.lr_we),     32'h0);
    check({pfx, "_ferr"},    32'(bus_if.fetch_err), 32'h0);
    check({pfx, "_lrdata"},  bus_if.lr_data,   32'h4);
  endtask

  // Runs one instruction starting in the first FETCH cycle; exp_pc is the hand-computed next PC.
  task automatic run_instr(input string nm, input logic ig, input logic wr, input logic be,
                           input logic lk, input logic br, input logic [23:0] off,
                           input logic [31:0] rm, input int ack_dly, input int stall,
                           input logic [31:0] exp_pc);
    logic [31:0] word;
    word = 32'hA500_0000 ^ cur_pc;
    check({nm, "_fetch_state"}, 32'(bus_if.state), 32'(ST_FETCH));
    check({nm, "_req"},         32'(bus_if.imem_req), 32'h1);
    check({nm, "_addr"},        bus_if.imem_addr, cur_pc);
    for (int i = 0; i < ack_dly; i++) begin
      bus_if.imem_ack = 1'b0;
      tick();
      check({nm, "_ackwait_state"}, 32'(bus_if.state), 32'(ST_FETCH));
      check({nm, "_ackwait_addr"},  bus_if.imem_addr, cur_pc);
    end
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = word;
    tick();
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = ~word;
    check({nm, "_dec_state"}, 32'(bus_if.state), 32'(ST_DEC));
    check({nm, "_ir"},        bus_if.ir, word);
    check({nm, "_req_drop"},  32'(bus_if.imem_req), 32'h0);
    bus_if.ig_ex       = ig;
    bus_if.write_rd    = wr;
    bus_if.br_en       = be;
    bus_if.link        = lk;
    bus_if.br_reg      = br;
    bus_if.br_offset24 = off;
    bus_if.rm_data     = ~rm;
    tick();
    if (ig) begin
      bus_if.ig_ex = 1'b0;
      check({nm, "_skip_state"}, 32'(bus_if.state), 32'(ST_FETCH));
      check({nm, "_skip_pc"},    bus_if.pc, exp_pc);
      check({nm, "_skip_cnt"},   bus_if.instr_cnt, exp_cnt + 32'd1);
      check({nm, "_skip_rfwe"},  32'(bus_if.rf_we), 32'h0);
      check({nm, "_skip_lrwe"},  32'(bus_if.lr_we), 32'h0);
    end else begin
      // Decoder outputs are don't-care after DECODE; scramble them.
      bus_if.write_rd    = ~wr;
      bus_if.br_en       = ~be;
      bus_if.link        = ~lk;
      bus_if.br_reg      = ~br;
      bus_if.br_offset24 = ~off;
      check({nm, "_exe_state"}, 32'(bus_if.state), 32'(ST_EXE));
      check({nm, "_exe_pc"},    bus_if.pc, cur_pc);
      for (int i = 0; i < stall; i++) begin
        bus_if.ex_stall = 1'b1;
        tick();
        check({nm, "_stall_state"}, 32'(bus_if.state), 32'(ST_EXE));
        check({nm, "_stall_rfwe"},  32'(bus_if.rf_we), 32'h0);
      end
      bus_if.ex_stall = 1'b0;
      bus_if.rm_data  = rm;
      tick();
      bus_if.rm_data  = 32'h0;
      check({nm, "_wb_state"},  32'(bus_if.state), 32'(ST_WB));
      check({nm, "_wb_rfwe"},   32'(bus_if.rf_we), 32'(wr));
      check({nm, "_wb_lrwe"},   32'(bus_if.lr_we), 32'(be & lk));
      check({nm, "_wb_lrdata"}, bus_if.lr_data, cur_pc + 32'd4);
      check({nm, "_wb_pc"},     bus_if.pc, cur_pc);
      tick();
      check({nm, "_nxt_state"}, 32'(bus_if.state), 32'(ST_FETCH));
      check({nm, "_nxt_pc"},    bus_if.pc, exp_pc);
      check({nm, "_nxt_cnt"},   bus_if.instr_cnt, exp_cnt + 32'd1);
      check({nm, "_nxt_rfwe"},  32'(bus_if.rf_we), 32'h0);
      check({nm, "_nxt_lrwe"},  32'(bus_if.lr_we), 32'h0);
    end
    bus_if.write_rd    = 1'b0;
    bus_if.br_en       = 1'b0;
    bus_if.link        = 1'b0;
    bus_if.br_reg      = 1'b0;
    bus_if.br_offset24 = 24'h0;
    cur_pc  = exp_pc;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    cur_pc  = 32'h0;
    exp_cnt = 32'h0;
    rst = 1'b1;
    bus_if.imem_ack    = 1'b0;
    bus_if.imem_rdata  = 32'h0;
    bus_if.ig_ex       = 1'b0;
    bus_if.write_rd    = 1'b0;
    bus_if.br_en       = 1'b0;
    bus_if.link        = 1'b0;
    bus_if.br_offset24 = 24'h0;
    bus_if.br_reg      = 1'b0;
    bus_if.rm_data     = 32'h0;
    bus_if.ex_stall    = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    chk_rst("rst0");

    rst = 1'b1;
    tick();
    check("boot_state", 32'(bus_if.state), 32'(ST_FETCH));

    //        name    ig    wr    be    lk    br    off          rm            ack stall next pc
    run_instr("plain", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 32'h0,        0,  0,   32'h0000_0004);
    run_instr("bx1",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000, 32'h0000_2001, 0, 3,   32'h0000_2000);
    run_instr("bxl",   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 32'h0000_0101, 0, 0,   32'h0000_0100);
    run_instr("bneg",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFE, 32'h0,        3,  0,   32'h0000_0100);
    run_instr("bx2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 32'h0000_0040, 0, 0,   32'h0000_0040);
    run_instr("bl",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000001, 32'h0,        0,  0,   32'h0000_004C);
    run_instr("skip",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000001, 32'h0,        0,  0,   32'h0000_0050);
    check("post_skip_addr", bus_if.imem_addr, 32'h0000_0050);

    // Fetch timeout: 16 FETCH cycles without ack, then HALT.
    for (int i = 1; i < 16; i++) begin
      tick();
      check("tmo_wait_state", 32'(bus_if.state), 32'(ST_FETCH));
    end
    tick();
    check("halt_state", 32'(bus_if.state), 32'(ST_HALT));
    check("halt_ferr",  32'(bus_if.fetch_err), 32'h1);
    check("halt_req",   32'(bus_if.imem_req), 32'h0);
    bus_if.imem_ack = 1'b1;
    tick();
    bus_if.imem_ack = 1'b0;
    check("halt_stays", 32'(bus_if.state), 32'(ST_HALT));

    // Reset from HALT, with a stray ack held through reset and the release cycle.
    #3 rst = 1'b0;
    #1 chk_rst("rst_halt");
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus_if.imem_ack = 1'b0;
    check("rel_state", 32'(bus_if.state), 32'(ST_FETCH));
    check("rel_ir",    bus_if.ir, 32'h0);
    check("rel_req",   32'(bus_if.imem_req), 32'h1);

    // Reset asserted mid-FETCH must act without waiting for a clock edge.
    tick();
    tick();
    #3 rst = 1'b0;
    #1 chk_rst("rst_fetch");
    tick();
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
